// File: rtl/key_motion_ctrl.sv
// Keycode-to-motion controller: synchronises the frame strobe, debounces the
// WASD keycode per frame and ramps the step size while a direction is held.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no valid key; motion zero
// ARM   | candidate direction seen, counting consecutive stable frames
// MOVE  | direction confirmed; motion = +/-speed, speed ramps with hold
module key_motion_ctrl #(
  parameter int STABLE_FRAMES = 2,
  parameter int MIN_STEP      = 1,
  parameter int MAX_STEP      = 4,
  parameter int ACCEL_FRAMES  = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic       frame_tick,
  output logic [9:0] motion_x,
  output logic [9:0] motion_y,
  output logic [1:0] dir,
  output logic       moving
);

  localparam int CNT_W  = $clog2(STABLE_FRAMES) + 1;
  localparam int HOLD_W = $clog2(ACCEL_FRAMES) + 1;

  localparam logic [CNT_W-1:0]  STABLE_C = CNT_W'(STABLE_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [HOLD_W-1:0] ACCEL_C  = HOLD_W'(ACCEL_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [7:0]        MIN_C    = 8'(MIN_STEP);
  localparam logic [7:0]        MAX_C    = 8'(MAX_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MOVE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  logic fclk_meta, fclk_sync, fclk_prev;

  // frame_clk is VGA_VS, unrelated to Clk: two flops for metastability, one for edge
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fclk_meta  <= 1'b0;
      fclk_sync  <= 1'b0;
      fclk_prev  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      fclk_meta  <= frame_clk;
      fclk_sync  <= fclk_meta;
      fclk_prev  <= fclk_sync;
      frame_tick <= fclk_sync & ~fclk_prev;
    end
  end

  logic key_valid;
  dir_t key_dir;

  always_comb begin
    key_valid = 1'b1;
    key_dir   = DIR_UP;
    case (keycode)
      8'h1A:   key_dir = DIR_UP;
      8'h16:   key_dir = DIR_DOWN;
      8'h04:   key_dir = DIR_LEFT;
      8'h07:   key_dir = DIR_RIGHT;
      default: key_valid = 1'b0;
    endcase
  end

  state_t            state, state_n;
  dir_t              cand, cand_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic [HOLD_W-1:0] hold, hold_n, hold_inc;
  logic [7:0]        speed, speed_n;
  logic [9:0]        mx_n, my_n, spd_pos, spd_neg;
  logic [1:0]        dir_n;
  logic              mv_n;

  assign cnt_inc  = cnt + CNT_ONE;
  assign hold_inc = hold + HOLD_ONE;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cand     <= DIR_UP;
      cnt      <= '0;
      hold     <= '0;
      speed    <= '0;
      motion_x <= '0;
      motion_y <= '0;
      dir      <= '0;
      moving   <= 1'b0;
    end else begin
      state    <= state_n;
      cand     <= cand_n;
      cnt      <= cnt_n;
      hold     <= hold_n;
      speed    <= speed_n;
      motion_x <= mx_n;
      motion_y <= my_n;
      dir      <= dir_n;
      moving   <= mv_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    hold_n  = hold;
    speed_n = speed;
    if (frame_tick) begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            cand_n = key_dir;
            cnt_n  = CNT_ONE;
            if (STABLE_FRAMES == 1) begin
              state_n = MOVE;
              speed_n = MIN_C;
              hold_n  = '0;
            end else begin
              state_n = ARM;
            end
          end
        end
        ARM: begin
          if (!key_valid) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (key_dir != cand) begin
            cand_n = key_dir;
            cnt_n  = CNT_ONE;
          end else begin
            cnt_n = cnt_inc;
            // >= rather than == so a one-frame debounce still leaves ARM after a reversal
            if (cnt_inc >= STABLE_C) begin
              state_n = MOVE;
              speed_n = MIN_C;
              hold_n  = '0;
            end
          end
        end
        MOVE: begin
          if (!key_valid) begin
            state_n = IDLE;
            speed_n = '0;
            hold_n  = '0;
            cnt_n   = '0;
          end else if (key_dir != cand) begin
            state_n = ARM;
            cand_n  = key_dir;
            cnt_n   = CNT_ONE;
            speed_n = '0;
            hold_n  = '0;
          end else if (hold_inc == ACCEL_C) begin
            hold_n  = '0;
            speed_n = (speed < MAX_C) ? speed + 8'd1 : MAX_C;
          end else begin
            hold_n = hold_inc;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // outputs are registered from next-state values so they land one Clk after frame_tick
  assign spd_pos = {2'b00, speed_n};
  assign spd_neg = ~spd_pos + 10'd1;

  always_comb begin
    mx_n  = '0;
    my_n  = '0;
    mv_n  = 1'b0;
    dir_n = dir;
    if (state_n == MOVE) begin
      mv_n  = 1'b1;
      dir_n = cand_n;
      case (cand_n)
        DIR_UP:    my_n = spd_neg;
        DIR_DOWN:  my_n = spd_pos;
        DIR_LEFT:  mx_n = spd_neg;
        DIR_RIGHT: mx_n = spd_pos;
        default:   mx_n = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_key_motion_ctrl.sv
// Scoreboard bench for key_motion_ctrl: each frame pushes the hand-computed
// response; a monitor pops and compares one Clk after every frame_tick.
module tb_key_motion_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       frame_tick;
  logic [9:0] motion_x, motion_y;
  logic [1:0] dir;
  logic       moving;

  key_motion_ctrl #(
    .STABLE_FRAMES(2),
    .MIN_STEP(1),
    .MAX_STEP(4),
    .ACCEL_FRAMES(8)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .keycode(keycode),
    .frame_tick(frame_tick),
    .motion_x(motion_x),
    .motion_y(motion_y),
    .dir(dir),
    .moving(moving)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0] mx;
    logic [9:0] my;
    logic [1:0] d;
    logic       mv;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [9:0] mx, input logic [9:0] my,
                              input logic [1:0] d, input logic mv);
    exp_t e;
    e.mx = mx;
    e.my = my;
    e.d  = d;
    e.mv = mv;
    return e;
  endfunction

  // monitor: outputs are compared on the negedge following the tick cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (frame_tick === 1'b1) begin
        @(negedge Clk);
        check("tick_width", {31'd0, frame_tick}, 32'd0);
        check("sb_pending", {31'd0, (sb_q.size() > 0)}, 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("motion_x", {22'd0, motion_x}, {22'd0, e.mx});
          check("motion_y", {22'd0, motion_y}, {22'd0, e.my});
          check("dir",      {30'd0, dir},      {30'd0, e.d});
          check("moving",   {31'd0, moving},   {31'd0, e.mv});
        end
      end
    end
  end

  // one VS pulse; key is held through the tick cycle, optional glitch afterwards
  task automatic frame(input logic [7:0] key, input logic glitch, input exp_t e);
    @(negedge Clk);
    keycode = key;
    sb_q.push_back(e);
    frame_clk = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge Clk);
      check("tick_latency", {31'd0, frame_tick}, (i == 3) ? 32'd1 : 32'd0);
    end
    @(negedge Clk);
    if (glitch) begin
      keycode = 8'h04;
      repeat (5) @(negedge Clk);
      keycode = 8'h00;
    end
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    int s;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b1;
    repeat (5) @(negedge Clk);
    check("tick_in_reset", {31'd0, frame_tick}, 32'd0);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_motion_x", {22'd0, motion_x}, 32'd0);
    check("rst_motion_y", {22'd0, motion_y}, 32'd0);
    check("rst_dir",      {30'd0, dir},      32'd0);
    check("rst_moving",   {31'd0, moving},   32'd0);

    // debounce: right needs two frames
    frame(8'h07, 1'b0, mk(10'd0, 10'd0, 2'd0, 1'b0));
    frame(8'h07, 1'b0, mk(10'd1, 10'd0, 2'd3, 1'b1));
    // release keeps dir
    frame(8'h00, 1'b0, mk(10'd0, 10'd0, 2'd3, 1'b0));
    // glitches between ticks are invisible
    frame(8'h00, 1'b1, mk(10'd0, 10'd0, 2'd3, 1'b0));
    frame(8'h00, 1'b1, mk(10'd0, 10'd0, 2'd3, 1'b0));

    // ramp up: -1,-2,-3,-4 every 8 frames, saturating at -4
    frame(8'h1A, 1'b0, mk(10'd0, 10'd0, 2'd3, 1'b0));
    for (int f = 2; f <= 42; f++) begin
      s = 1 + (f - 2) / 8;
      if (s > 4) s = 4;
      frame(8'h1A, 1'b0, mk(10'd0, 10'(-s), 2'd0, 1'b1));
    end
    // unknown key behaves as release
    frame(8'h2C, 1'b0, mk(10'd0, 10'd0, 2'd0, 1'b0));

    // reach right at speed 3, then reverse
    frame(8'h07, 1'b0, mk(10'd0, 10'd0, 2'd0, 1'b0));
    for (int f = 2; f <= 18; f++) begin
      s = 1 + (f - 2) / 8;
      frame(8'h07, 1'b0, mk(10'(s), 10'd0, 2'd3, 1'b1));
    end
    frame(8'h04, 1'b0, mk(10'd0, 10'd0, 2'd3, 1'b0));
    frame(8'h04, 1'b0, mk(10'h3FF, 10'd0, 2'd2, 1'b1));
    frame(8'h04, 1'b0, mk(10'h3FF, 10'd0, 2'd2, 1'b1));

    // async reset mid-MOVE clears outputs without waiting for a clock edge
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("midrst_motion_x", {22'd0, motion_x}, 32'd0);
    check("midrst_motion_y", {22'd0, motion_y}, 32'd0);
    check("midrst_dir",      {30'd0, dir},      32'd0);
    check("midrst_moving",   {31'd0, moving},   32'd0);
    check("midrst_tick",     {31'd0, frame_tick}, 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // FSM restarted in IDLE: one frame only arms
    frame(8'h07, 1'b0, mk(10'd0, 10'd0, 2'd0, 1'b0));
    frame(8'h07, 1'b0, mk(10'd1, 10'd0, 2'd3, 1'b1));

    repeat (10) @(negedge Clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
